if_id_stage_skid: RTL and testbench
===================================

Name: if_id_stage_skid

Overview:
- Parametrised successor to the fixed-width IF/ID latch.
- Carries {instruction address, instruction} from the fetch stage to decode, using a valid/ready handshake, synchronous flush and an optional 2-entry skid buffer.
- Downstream stall (hazard detection, deasserted ready) never loses an accepted fetch.
- Presents pre-sliced MIPS fields to decode and keeps a saturating stall-cycle counter for performance debug.

Parameters:
- ADDR_W, 32, width of instruction address.
- NOP_INST, 32'hFC000000, instruction word presented whenever the stage holds no valid entry (bubble encoding).
- SKID, 1, 1 = 2-entry skid buffer (ready_o registered); 0 = single entry (ready_o combinational from ready_i).
- CNT_W, 16, width of stall counter.

Ports:
- clk_i, input, 1, clock, rising edge.
- rst_i, input, 1, asynchronous active-high reset.
- valid_i, input, 1, fetch presents an instruction.
- ready_o, output, 1, stage can accept this cycle.
- addr_i, input, ADDR_W, instruction address from fetch.
- inst_i, input, 32, instruction word from fetch.
- flush_i, input, 1, synchronous flush (branch/jump taken).
- valid_o, output, 1, decode-side entry valid.
- ready_i, input, 1, decode accepts; driven low by hazard detection to stall.
- addr_o, output, ADDR_W, held address.
- inst_o, output, 32, held instruction (NOP_INST when valid_o=0).
- op_o, output, 6, inst_o[31:26].
- rs_o, output, 5, inst_o[25:21].
- rt_o, output, 5, inst_o[20:16].
- rd_o, output, 5, inst_o[15:11].
- imm_o, output, 16, inst_o[15:0].
- jidx_o, output, 26, inst_o[25:0].
- cnt_clr_i, input, 1, synchronous clear of stall counter.
- stall_cnt_o, output, CNT_W, cycles with valid_o=1 and ready_i=0.

Behaviour:
- Handshakes:
  - fire_in = valid_i & ready_o.
  - fire_out = valid_o & ready_i.
- Storage:
  - Main register (valid_q, addr_q, inst_q) drives valid_o/addr_o/inst_o directly. All field outputs are pure slices of inst_q. Zero combinational path from inputs to data outputs.
  - An invalid main entry always holds inst_q=NOP_INST and addr_q=0.
- SKID=1:
  - ready_o = ~skid_v (registered).
  - Main loads when ready_i | ~valid_q:
    - skid_v=1 → main takes the skid entry; skid_v clears.
    - else fire_in → main takes the input.
    - else main becomes invalid (NOP/0).
  - When ~ready_i & valid_q & fire_in → skid captures the input; skid_v=1.
  - Upstream may have one word in flight when the stall arrives. The skid absorbs it, so total capacity is 2.
- SKID=0:
  - ready_o = ready_i | ~valid_q.
  - Main loads the input on fire_in, else goes invalid if fire_out.
  - Skid logic is absent.
- Latency: an input accepted at edge N appears on valid_o/inst_o after edge N (1 cycle) when the stage is not stalled. Throughput is 1/cycle.
- Order: strictly FIFO; the skid entry always precedes any newer input.
- Flush:
  - Highest priority over all data movement.
  - At the edge with flush_i=1, valid_q←0, inst_q←NOP_INST, addr_q←0, skid_v←0.
  - Any input fired in the same cycle is dropped.
  - Downstream must not treat a fire_out in the flush cycle as discarded; it is delivered.
- Simultaneous stall+flush: flush wins; the stage is empty next cycle and ready_o=1.
- Reset (async, any time, including mid-stall):
  - valid_o=0, inst_o=NOP_INST, addr_o=0, skid empty, ready_o=1 (SKID=1), stall_cnt_o=0.
  - Fields are reset to slices of NOP_INST: op_o=6'h3F, all others 0 with the default parameter.
- Stall counter:
  - Increments each cycle valid_o & ~ready_i.
  - Saturates at all-ones.
  - cnt_clr_i has priority over increment; cleared value is 0 next cycle.
  - Flush does not affect the counter.

Test Plan:
- Reset mid-stream (skid full, rst_i pulsed between edges) → immediately valid_o=0, inst_o=32'hFC000000, op_o=6'h3F, ready_o=1, stall_cnt_o=0.
- Stream 4 words A0..A3 (addr 0,4,8,C) with ready_i=1 → each appears 1 cycle later in order; fields match (inst 0x012A4020 → op 0, rs 9, rt 10, rd 8, imm 0x4020).
- SKID=1: ready_i=0 while valid_i=1 for 3 cycles → main holds A0, skid holds A1, ready_o=0 from next cycle; release → A0, A1, A2 in order, no loss or duplicate; stall_cnt_o=3.
- Flush while skid full and valid_i=1 → next cycle valid_o=0, inst_o=NOP_INST, ready_o=1; the dropped input never appears.
- SKID=0: ready_i=0 → ready_o=0 same cycle, entry held stable; ready_i=1 → ready_o=1 and the next word is loaded 1 cycle later.
- CNT_W=4: stall 20 cycles → stall_cnt_o saturates at 15; cnt_clr_i with stall active → 0 next cycle, then counts again.

Source files
------------

// File: rtl/if_id_stage_skid.sv
// IF/ID pipeline register with valid/ready handshake, flush, optional 2-entry skid
// buffer, pre-sliced MIPS fields and a saturating stall-cycle counter.
module if_id_stage_skid #(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] NOP_INST = 32'hFC000000,
    parameter bit          SKID     = 1'b1,
    parameter int          CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       inst_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [31:0]       inst_o,
    output logic [5:0]        op_o,
    output logic [4:0]        rs_o,
    output logic [4:0]        rt_o,
    output logic [4:0]        rd_o,
    output logic [15:0]       imm_o,
    output logic [25:0]       jidx_o,
    input  logic              cnt_clr_i,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       inst_q;
    logic              skid_v;
    logic [ADDR_W-1:0] skid_addr;
    logic [31:0]       skid_inst;
    logic [CNT_W-1:0]  cnt_q;
    logic              fire_in;
    logic              fire_out;
    logic              load_main;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        if (&val) return val;
        return val + 1'b1;
    endfunction

    assign fire_in  = valid_i & ready_o;
    assign fire_out = valid_o & ready_i;

    generate
        if (SKID) begin : g_skid
            assign ready_o   = ~skid_v;
            assign load_main = ready_i | ~valid_q;

            // Skid catches the word that was already in flight when the stall arrived.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    skid_v    <= 1'b0;
                    skid_addr <= '0;
                    skid_inst <= NOP_INST;
                end else if (flush_i) begin
                    skid_v <= 1'b0;
                end else if (load_main && skid_v) begin
                    skid_v <= 1'b0;
                end else if (!ready_i && valid_q && fire_in) begin
                    skid_v    <= 1'b1;
                    skid_addr <= addr_i;
                    skid_inst <= inst_i;
                end
            end
        end else begin : g_noskid
            assign ready_o   = ready_i | ~valid_q;
            assign load_main = fire_in | fire_out;
            assign skid_v    = 1'b0;
            assign skid_addr = '0;
            assign skid_inst = NOP_INST;
        end
    endgenerate

    // Main entry: skid has precedence over new input to keep FIFO order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            inst_q  <= NOP_INST;
        end else if (flush_i) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            inst_q  <= NOP_INST;
        end else if (load_main) begin
            if (skid_v) begin
                valid_q <= 1'b1;
                addr_q  <= skid_addr;
                inst_q  <= skid_inst;
            end else if (fire_in) begin
                valid_q <= 1'b1;
                addr_q  <= addr_i;
                inst_q  <= inst_i;
            end else begin
                valid_q <= 1'b0;
                addr_q  <= '0;
                inst_q  <= NOP_INST;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (cnt_clr_i) begin
            cnt_q <= '0;
        end else if (valid_q && !ready_i) begin
            cnt_q <= sat_inc(cnt_q);
        end
    end

    assign valid_o     = valid_q;
    assign addr_o      = addr_q;
    assign inst_o      = inst_q;
    assign op_o        = inst_q[31:26];
    assign rs_o        = inst_q[25:21];
    assign rt_o        = inst_q[20:16];
    assign rd_o        = inst_q[15:11];
    assign imm_o       = inst_q[15:0];
    assign jidx_o      = inst_q[25:0];
    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_if_id_stage_skid.sv
// Directed bench for if_id_stage_skid: one skid instance (CNT_W=4) and one
// single-entry instance share the same stimulus.
module tb_if_id_stage_skid;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [31:0] addr_i;
    logic [31:0] inst_i;
    logic        flush_i;
    logic        ready_i;
    logic        cnt_clr_i;

    logic        r1, v1;
    logic [31:0] a1, i1;
    logic [5:0]  op1;
    logic [4:0]  rs1, rt1, rd1;
    logic [15:0] imm1;
    logic [25:0] j1;
    logic [3:0]  c1;

    logic        r0, v0;
    logic [31:0] a0, i0;
    logic [5:0]  op0;
    logic [4:0]  rs0, rt0, rd0;
    logic [15:0] imm0;
    logic [25:0] j0;
    logic [15:0] c0;

    int passed = 0;
    int total  = 0;

    localparam logic [31:0] NOP = 32'hFC000000;

    always #5 clk = ~clk;

    if_id_stage_skid #(.ADDR_W(32), .NOP_INST(NOP), .SKID(1'b1), .CNT_W(4)) u_skid (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(r1),
        .addr_i(addr_i), .inst_i(inst_i), .flush_i(flush_i),
        .valid_o(v1), .ready_i(ready_i), .addr_o(a1), .inst_o(i1),
        .op_o(op1), .rs_o(rs1), .rt_o(rt1), .rd_o(rd1), .imm_o(imm1), .jidx_o(j1),
        .cnt_clr_i(cnt_clr_i), .stall_cnt_o(c1)
    );

    if_id_stage_skid #(.ADDR_W(32), .NOP_INST(NOP), .SKID(1'b0), .CNT_W(16)) u_noskid (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(r0),
        .addr_i(addr_i), .inst_i(inst_i), .flush_i(flush_i),
        .valid_o(v0), .ready_i(ready_i), .addr_o(a0), .inst_o(i0),
        .op_o(op0), .rs_o(rs0), .rt_o(rt0), .rd_o(rd0), .imm_o(imm0), .jidx_o(j0),
        .cnt_clr_i(cnt_clr_i), .stall_cnt_o(c0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] i);
        valid_i = v;
        addr_i  = a;
        inst_i  = i;
    endtask

    logic [31:0] wa [4];
    logic [31:0] wi [4];

    initial begin
        wa[0] = 32'h0;  wi[0] = 32'h012A4020;
        wa[1] = 32'h4;  wi[1] = 32'h8D090004;
        wa[2] = 32'h8;  wi[2] = 32'h08000010;
        wa[3] = 32'hC;  wi[3] = 32'hAD2A0008;

        rst = 1'b1; flush_i = 1'b0; ready_i = 1'b1; cnt_clr_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        tick(); tick();
        chk("rst_valid", v1, 0);
        chk("rst_inst", i1, NOP);
        chk("rst_op", op1, 6'h3F);
        chk("rst_addr", a1, 0);
        chk("rst_ready", r1, 1);
        chk("rst_cnt", c1, 0);
        chk("rst_jidx", j1, 0);
        chk("rst_inst0", i0, NOP);
        rst = 1'b0;

        // Streaming with ready_i=1
        drive(1'b1, wa[0], wi[0]);
        tick();
        chk("a0_valid", v1, 1);
        chk("a0_inst", i1, wi[0]);
        chk("a0_op", op1, 0);
        chk("a0_rs", rs1, 9);
        chk("a0_rt", rt1, 10);
        chk("a0_rd", rd1, 8);
        chk("a0_imm", imm1, 16'h4020);
        chk("a0_jidx", j1, 26'h12A4020);
        chk("a0_inst0", i0, wi[0]);
        for (int k = 1; k < 4; k++) begin
            drive(1'b1, wa[k], wi[k]);
            tick();
            chk("str_inst", i1, wi[k]);
            chk("str_addr", a1, wa[k]);
            chk("str_inst0", i0, wi[k]);
            if (k == 1) begin
                chk("a1_op", op1, 6'h23);
                chk("a1_rt", rt1, 9);
            end
            if (k == 2) begin
                chk("a2_op", op1, 6'h02);
                chk("a2_jidx", j1, 26'h10);
            end
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("str_end_valid", v1, 0);
        chk("str_end_inst", i1, NOP);
        chk("str_cnt", c1, 0);

        // Skid stall: A0 held, A1 absorbed, A2 waits
        ready_i = 1'b0;
        drive(1'b1, wa[0], wi[0]);
        tick();
        chk("st_main_a0", i1, wi[0]);
        chk("st_ready1", r1, 1);
        drive(1'b1, wa[1], wi[1]);
        tick();
        chk("st_ready0", r1, 0);
        chk("st_hold_a0", i1, wi[0]);
        chk("st_cnt1", c1, 1);
        drive(1'b1, wa[2], wi[2]);
        tick();
        tick();
        chk("st_hold2_a0", i1, wi[0]);
        chk("st_ready0b", r1, 0);
        chk("st_cnt3", c1, 3);
        ready_i = 1'b1;
        tick();
        chk("rel_a1", i1, wi[1]);
        chk("rel_a1_addr", a1, wa[1]);
        chk("rel_ready", r1, 1);
        chk("rel_cnt", c1, 3);
        tick();
        chk("rel_a2", i1, wi[2]);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("rel_empty", v1, 0);

        // Flush with skid full and input pending
        ready_i = 1'b0;
        drive(1'b1, 32'h10, 32'h20080001);
        tick();
        drive(1'b1, 32'h14, 32'h20090002);
        tick();
        chk("fl_skidfull", r1, 0);
        drive(1'b1, 32'h18, 32'h200A0003);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("fl_valid", v1, 0);
        chk("fl_inst", i1, NOP);
        chk("fl_addr", a1, 0);
        chk("fl_ready", r1, 1);
        chk("fl_cnt", c1, 5);
        ready_i = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("fl_no_skid", v1, 0);
        drive(1'b1, 32'h1C, 32'h200B0004);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("fl_drop_fired", v1, 0);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("fl_drop_after", i1, NOP);

        // Async reset mid-stall with skid full
        ready_i = 1'b0;
        drive(1'b1, 32'h20, 32'h11111111);
        tick();
        drive(1'b1, 32'h24, 32'h22222222);
        tick();
        chk("mr_skidfull", r1, 0);
        rst = 1'b1;
        #2;
        chk("mr_valid", v1, 0);
        chk("mr_inst", i1, NOP);
        chk("mr_op", op1, 6'h3F);
        chk("mr_ready", r1, 1);
        chk("mr_cnt", c1, 0);
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        #2;

        // Counter saturation and clear
        drive(1'b1, 32'h30, 32'h33333333);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        for (int n = 0; n < 20; n++) tick();
        chk("cnt_sat", c1, 15);
        cnt_clr_i = 1'b1;
        tick();
        cnt_clr_i = 1'b0;
        chk("cnt_clr", c1, 0);
        tick();
        chk("cnt_after1", c1, 1);
        tick();
        chk("cnt_after2", c1, 2);

        // Single-entry variant
        rst = 1'b1;
        #2;
        rst = 1'b0;
        ready_i = 1'b1;
        drive(1'b1, 32'h40, 32'h3C011234);
        tick();
        chk("ns_e0", i0, 32'h3C011234);
        ready_i = 1'b0;
        drive(1'b1, 32'h44, 32'h34210005);
        #1;
        chk("ns_ready0", r0, 0);
        tick();
        chk("ns_hold_inst", i0, 32'h3C011234);
        chk("ns_hold_addr", a0, 32'h40);
        tick();
        chk("ns_hold2", i0, 32'h3C011234);
        ready_i = 1'b1;
        #1;
        chk("ns_ready1", r0, 1);
        tick();
        chk("ns_e1", i0, 32'h34210005);
        chk("ns_e1_addr", a0, 32'h44);
        chk("ns_cnt", c0, 2);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("ns_empty", v0, 0);
        chk("ns_empty_inst", i0, NOP);
        ready_i = 1'b0;
        #1;
        chk("ns_ready_empty", r0, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
